// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU among NUM_REQ requesters. A round-robin
// arbiter accepts one request at a time, holds its operation in registers
// that drive the ALU for one cycle, then returns the captured result
// tagged with the requester index. At most one operation is in flight.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          per-requester request handshake (ready one-hot or zero)
//   req_fn/req_funct7/req_a/req_b  per-requester operation, requester i at slice i
//   alu_fn/alu_funct7/alu_a/alu_b  operation presented to the shared ALU
//   alu_out                      shared ALU result
//   rsp_valid/rsp_ready          response handshake
//   rsp_id/rsp_data              issuing requester index and result
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int FN_W    = 3,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FN_W-1:0]  req_fn,
    input  logic [NUM_REQ*7-1:0]     req_funct7,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [FN_W-1:0]          alu_fn,
    output logic [6:0]               alu_funct7,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [FN_W-1:0]     r_op_fn;
    logic [6:0]          r_op_funct7;
    logic [WIDTH-1:0]    r_op_a;
    logic [WIDTH-1:0]    r_op_b;
    logic [ID_W-1:0]     r_op_id;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [WIDTH-1:0]    r_rsp_data;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_grant_any;
    logic [ID_W-1:0]     w_grant_id;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_idx;
    logic [ID_W-1:0]     w_ptr_next;
    logic [FN_W-1:0]     w_sel_fn;
    logic [6:0]          w_sel_funct7;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;

    // Round-robin scan starting at r_rr_ptr. The wrap is an explicit
    // subtraction so non-power-of-two NUM_REQ never yields an index
    // outside 0..NUM_REQ-1. Only req_valid feeds this path.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_grant_any && req_valid[w_idx]) begin
                w_grant_any    = 1'b1;
                w_grant_id     = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_fn     = '0;
        w_sel_funct7 = '0;
        w_sel_a      = '0;
        w_sel_b      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_fn     = req_fn[i*FN_W +: FN_W];
                w_sel_funct7 = req_funct7[i*7 +: 7];
                w_sel_a      = req_a[i*WIDTH +: WIDTH];
                w_sel_b      = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                req_ready = w_grant;
                if (w_grant_any) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: w_state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_op_fn     <= '0;
            r_op_funct7 <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_op_fn     <= w_sel_fn;
                        r_op_funct7 <= w_sel_funct7;
                        r_op_a      <= w_sel_a;
                        r_op_b      <= w_sel_b;
                        r_op_id     <= w_grant_id;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu_out;
                    r_rsp_id    <= r_op_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    // ALU inputs come straight from the op registers in every state.
    assign alu_fn     = r_op_fn;
    assign alu_funct7 = r_op_funct7;
    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SLTU = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_OR   = 3'd6;
    localparam logic [2:0] FN_AND  = 3'd7;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_fn;
    logic [13:0] req_funct7;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [2:0]  alu_fn;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.NUM_REQ(2), .WIDTH(32), .FN_W(3), .ID_W(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fn(req_fn), .req_funct7(req_funct7), .req_a(req_a), .req_b(req_b),
        .alu_fn(alu_fn), .alu_funct7(alu_funct7), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // Shared ALU stand-in (RISC-V funct3 style fn codes).
    function automatic logic [31:0] alu_f(input logic [2:0] fn, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
        case (fn)
            3'd0: return f7[5] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'b0, $signed(a) < $signed(b)};
            3'd3: return {31'b0, a < b};
            3'd4: return a ^ b;
            3'd5: return f7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_out = alu_f(alu_fn, alu_funct7, alu_a, alu_b);

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected grant from the arbitration rule: first valid index at or after ptr.
    function automatic logic [1:0] rr_grant(input logic [1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (v[idx]) return 2'(1 << idx);
        end
        return 2'b00;
    endfunction

    // Transaction-level model: busy from grant until response handshake,
    // response appears two cycles after grant.
    bit          primed = 0;
    int          cyc = 0;
    bit          m_busy;
    int          m_age;
    int          m_ptr;
    int          m_id;
    logic [2:0]  m_fn;
    logic [6:0]  m_f7;
    logic [31:0] m_a, m_b;
    int          m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  exp_ready;
    logic [1:0]  mon_ready = 2'b00;
    bit          prev_rv = 0;

    int          gnt_id[$];
    int          gnt_cyc[$];
    int          rise_cyc[$];
    int          rsp_ids[$];
    logic [31:0] rsp_dat[$];

    always @(negedge clk) begin
        cyc++;
        mon_ready = req_ready;
        exp_ready = m_busy ? 2'b00 : rr_grant(req_valid, m_ptr);
        if (primed) begin
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, m_busy && m_age == 2);
            chk("rsp_id", rsp_id, m_rid);
            chk("rsp_data", rsp_data, m_rdata);
            chk("alu_fn", alu_fn, m_fn);
            chk("alu_funct7", alu_funct7, m_f7);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (!rst) begin
                if (exp_ready != 2'b00) begin
                    gnt_id.push_back(exp_ready[1] ? 1 : 0);
                    gnt_cyc.push_back(cyc);
                end
                if (rsp_valid && !prev_rv) rise_cyc.push_back(cyc);
                if (rsp_valid && rsp_ready) begin
                    rsp_ids.push_back(int'(rsp_id));
                    rsp_dat.push_back(rsp_data);
                end
            end
        end
        prev_rv = rsp_valid;
        if (rst) begin
            primed = 1;
            m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0;
            m_fn = '0; m_f7 = '0; m_a = '0; m_b = '0;
            m_rid = 0; m_rdata = '0;
        end else if (!m_busy) begin
            if (exp_ready != 2'b00) begin
                m_id   = exp_ready[1] ? 1 : 0;
                m_fn   = req_fn[m_id*3 +: 3];
                m_f7   = req_funct7[m_id*7 +: 7];
                m_a    = req_a[m_id*32 +: 32];
                m_b    = req_b[m_id*32 +: 32];
                m_ptr  = (m_id + 1) % NREQ;
                m_busy = 1;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            m_rid   = m_id;
            m_rdata = alu_f(m_fn, m_f7, m_a, m_b);
            m_age   = 2;
        end else if (rsp_ready) begin
            m_busy = 0;
            m_age  = 0;
        end
    end

    bit auto_drop = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) begin
            for (int i = 0; i < NREQ; i++) begin
                if (mon_ready[i]) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] fn, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
        req_fn[i*3 +: 3]     = fn;
        req_funct7[i*7 +: 7] = f7;
        req_a[i*32 +: 32]    = a;
        req_b[i*32 +: 32]    = b;
        req_valid[i]         = 1'b1;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return gnt_id.size();
            1: return rise_cyc.size();
            default: return rsp_ids.size();
        endcase
    endfunction

    // which: 0 grants, 1 rsp_valid rises, 2 response handshakes
    task automatic wait_n(input int which, input int n, input int budget, input string name);
        int t;
        t = 0;
        while (qsize(which) < n && t < budget) begin
            tick();
            t++;
        end
        if (qsize(which) < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timed out after %0d cycles, got %0d events expected %0d",
                     name, budget, qsize(which), n);
        end
    endtask

    initial begin
        int g0, r0, s0, s1;
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};
        rst = 1'b1; req_valid = '0; req_fn = '0; req_funct7 = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Contention: both valid from reset.
        set_req(0, FN_XOR, 7'h00, 32'hF0, 32'hFF);
        set_req(1, FN_OR,  7'h00, 32'd1, 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_alu_a", alu_a, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        auto_drop = 1;
        wait_n(2, 2, 20, "contention_rsp");
        if (rsp_ids.size() >= 2) begin
            chk("contention_id0", rsp_ids[0], 0);
            chk("contention_data0", rsp_dat[0], 32'h0F);
            chk("contention_id1", rsp_ids[1], 1);
            chk("contention_data1", rsp_dat[1], 32'h3);
        end

        // Single ADD on requester 0, latency and valid drop.
        g0 = gnt_id.size(); r0 = rise_cyc.size(); s0 = rsp_ids.size();
        set_req(0, FN_ADD, 7'h00, 32'd5, 32'd3);
        wait_n(2, s0 + 1, 20, "add_rsp");
        if (rsp_ids.size() > s0 && rise_cyc.size() > r0 && gnt_id.size() > g0) begin
            chk("add_grant_id", gnt_id[g0], 0);
            chk("add_latency", rise_cyc[r0] - gnt_cyc[g0], 2);
            chk("add_data", rsp_dat[s0], 32'd8);
            chk("add_id", rsp_ids[s0], 0);
        end
        @(negedge clk); #1;
        chk("add_valid_drop", rsp_valid, 1'b0);
        @(posedge clk); #1;

        // SUB via funct7 on requester 1.
        s0 = rsp_ids.size();
        set_req(1, FN_ADD, 7'h20, 32'd10, 32'd3);
        wait_n(2, s0 + 1, 20, "sub_rsp");
        if (rsp_ids.size() > s0) begin
            chk("sub_data", rsp_dat[s0], 32'd7);
            chk("sub_id", rsp_ids[s0], 1);
        end

        // Fairness: both held valid for six grants.
        auto_drop = 0;
        s0 = rsp_ids.size(); g0 = gnt_id.size();
        set_req(0, FN_AND,  7'h00, 32'hFFFF, 32'h0F0F);
        set_req(1, FN_SLTU, 7'h00, 32'd3, 32'd9);
        wait_n(0, g0 + 6, 40, "fair_gnt");
        req_valid = '0;
        auto_drop = 1;
        wait_n(2, s0 + 6, 30, "fair_rsp");
        for (int k = 0; k < 6; k++) begin
            if (rsp_ids.size() > s0 + k) begin
                chk("fair_order", rsp_ids[s0 + k], exp_order[k]);
                chk("fair_data", rsp_dat[s0 + k], (exp_order[k] == 0) ? 32'h0F0F : 32'h1);
            end
        end

        // Backpressure: rsp_ready low for 4 cycles, requester 1 waiting.
        rsp_ready = 1'b0;
        r0 = rise_cyc.size(); s0 = rsp_ids.size();
        set_req(0, FN_AND,  7'h00, 32'hFF00FF00, 32'h0FF00FF0);
        set_req(1, FN_SLTU, 7'h00, 32'd1, 32'd2);
        wait_n(1, r0 + 1, 20, "bp_rise");
        repeat (3) begin
            @(negedge clk); #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, 32'h0F000F00);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_hs_valid", rsp_valid, 1'b1);
        chk("bp_hs_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("bp_regrant", req_ready, 2'b10);
        wait_n(2, s0 + 2, 20, "bp_rsp");
        if (rsp_ids.size() > s0 + 1) begin
            chk("bp_first_data", rsp_dat[s0], 32'h0F000F00);
            chk("bp_second_id", rsp_ids[s0 + 1], 1);
            chk("bp_second_data", rsp_dat[s0 + 1], 32'h1);
        end

        // Reset while in EXEC: op discarded, pointer back to 0.
        g0 = gnt_id.size(); s0 = rsp_ids.size();
        set_req(0, FN_ADD, 7'h00, 32'd100, 32'd200);
        wait_n(0, g0 + 1, 20, "rst_gnt");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        @(posedge clk); #1;
        s1 = rsp_ids.size();
        chk("rst_discard", s1 - s0, 0);
        set_req(1, FN_OR,  7'h00, 32'd4, 32'd8);
        set_req(0, FN_XOR, 7'h00, 32'd6, 32'd3);
        wait_n(2, s1 + 2, 30, "rst_rsp");
        if (rsp_ids.size() > s1 + 1) begin
            chk("rst_first_id", rsp_ids[s1], 0);
            chk("rst_first_data", rsp_dat[s1], 32'd5);
            chk("rst_second_id", rsp_ids[s1 + 1], 1);
            chk("rst_second_data", rsp_dat[s1 + 1], 32'd12);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu instance among NUM_REQ requesters (decode, branch-compare, address-gen units).
- Round-robin grant over a valid/ready request channel; registers the selected operation and drives the shared ALU for one cycle.
- Captures the result and returns it, tagged with the requester index, on a valid/ready response channel.
- At most one operation in flight.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- WIDTH, 32, operand/result width; must equal the shared ALU WIDTH
- FN_W, 3, width of packed ALU_FN_t
- ID_W, $clog2(NUM_REQ) (min 1), width of the response tag

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_fn  in  NUM_REQ*FN_W  per-requester ALU_FN_t, requester i at slice i
- req_funct7  in  NUM_REQ*7  per-requester funct7
- req_a  in  NUM_REQ*WIDTH  per-requester operand a
- req_b  in  NUM_REQ*WIDTH  per-requester operand b
- alu_fn  out  FN_W  to shared ALU fn
- alu_funct7  out  7  to shared ALU funct7
- alu_a  out  WIDTH  to shared ALU a
- alu_b  out  WIDTH  to shared ALU b
- alu_out  in  WIDTH  from shared ALU out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of requester that issued the result
- rsp_data  out  WIDTH  result

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset values:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - Op registers (fn, funct7, a, b, id) = 0, so alu_* = 0.
  - req_ready=0 out of reset is not required: it is combinational from IDLE, see below.
- Grant (combinational, IDLE only):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first i with req_valid[i]=1 gets grant[i]=1.
  - req_ready = grant in IDLE, all-zero in EXEC/RESP.
  - req_ready must not depend on any requester's data fields.
- IDLE, when any grant: the edge latches fn, funct7, a, b and id of the granted requester into op regs; rr_ptr <= (id+1) mod NUM_REQ; state -> EXEC. With no req_valid, remain IDLE and rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_* driven from op regs; drive them from op regs in every state so no glitch occurs.
  - The edge latches rsp_data <= alu_out and rsp_id <= op id; rsp_valid <= 1; state -> RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id stable until handshake.
  - On rsp_valid&rsp_ready: rsp_valid <= 0, state -> IDLE.
  - rsp_ready low holds indefinitely; no new grant while in RESP.
- Latency: request handshake at cycle N -> rsp_valid first high at cycle N+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Requester contract: req_valid and its data held stable until req_ready. A request dropped before grant is simply not issued.
- Arithmetic: none in this block; widths pass through unmodified. NUM_REQ not a power of 2: the rr_ptr wrap is explicit mod NUM_REQ, and a pointer value >= NUM_REQ never occurs.
- Simultaneous events:
  - All requesters valid: exactly one grant, the requester nearest rr_ptr.
  - The handshake on rsp in RESP and a new req_valid in the same cycle: no grant that cycle; grant is in the following IDLE cycle.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, rsp_valid=0 the next cycle, rr_ptr=0, no response is ever produced for it.
- X-safety: an unknown fn from a requester is forwarded unchanged. The ALU default handling is not this block's concern.

Test Plan:
- Single ADD, requester 0:
  - Stimulus: fn=ADD_SUB, funct7=0, a=5, b=3, rsp_ready=1.
  - Required: req_ready[0]=1 at cycle N; rsp_valid=1 at N+2 with rsp_data=8, rsp_id=0; rsp_valid=0 at N+3.
- SUB via funct7, requester 1:
  - Stimulus: fn=ADD_SUB, funct7=7'h20, a=10, b=3.
  - Required: rsp_data=7, rsp_id=1.
- Contention:
  - Stimulus: both requesters valid from reset, held until accepted: req0 XOR a=0xF0 b=0xFF; req1 OR a=1 b=2.
  - Required: req0 granted first (rsp_data=0x0F, id=0); req1 granted in the next IDLE (rsp_data=3, id=1).
- Fairness:
  - Stimulus: req0 and req1 valid continuously for 6 grants.
  - Required: grant order 0,1,0,1,0,1; never two consecutive grants to the same requester while the other is valid.
- Backpressure:
  - Stimulus: rsp_ready=0 for 4 cycles after rsp_valid rises, req1 valid throughout.
  - Required: rsp_data/rsp_id stable all 4 cycles; req_ready stays 0; req1 granted in the first cycle after the rsp handshake.
- Reset mid-op:
  - Stimulus: assert rst for 1 cycle while in EXEC.
  - Required: next cycle rsp_valid=0, state IDLE, alu_a=alu_b=0; the following request to requester 1 (with req0 also valid) grants req0 first (rr_ptr=0).
